kernel_border_stream: RTL

KERNEL_BORDER_STREAM -- requirements
Module: kernel_border_stream

---
 rtl/kernel_pkg.sv | 16 +
 rtl/line_buffer.sv | 36 +++
 rtl/kernel_border_stream.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/kernel_pkg.sv
// Shared types and constants for the kernel border streamer.
//   state_e : FILL / STREAM / FLUSH frame-phase encoding
//   MODE_4N : cross window (centre + N/S/E/W)
//   MODE_8N : full 3x3 window
package kernel_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  localparam logic MODE_4N = 1'b0;
  localparam logic MODE_8N = 1'b1;

endpackage

// File: rtl/line_buffer.sv
// Shift-register line buffer: delays a pixel stream by DEPTH accepted samples.
//   clk  : clock
//   en   : shift enable (one pixel step)
//   din  : pixel entering the buffer
//   dout : pixel that entered DEPTH steps ago (oldest entry)
// Contents are intentionally not reset; the owner masks stale data.
module line_buffer #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/kernel_border_stream.sv
// Streaming 3x3 / cross neighbourhood border classifier.
// Pixels arrive in raster order; each output is the centre pixel, or 0 with
// out_border set when (max - min) over the window reaches THRESH.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mode_8n             : 1 = 8-neighbour window, 0 = 4-neighbour cross
//   in_valid/in_ready   : input handshake, in_data = pixel
//   out_valid/out_ready : output handshake, out_data/out_border/out_last
//   busy                : frame in progress
//   dbg_state           : current frame phase
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid never waits for ready, and a held output stays stable.
module kernel_border_stream
  import kernel_pkg::*;
#(
  parameter int            DW     = 8,
  parameter int            IMG_W  = 8,
  parameter int            IMG_H  = 8,
  parameter logic [DW-1:0] THRESH = DW'(1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode_8n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_border,
  output logic          out_last,
  output logic          busy,
  output state_e        dbg_state
);

  localparam int NW = $clog2(IMG_W*IMG_H + 1);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [NW-1:0] FILL_LAST = NW'(IMG_W);
  localparam logic [NW-1:0] IN_LAST   = NW'(IMG_W*IMG_H - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);

  state_e        state_q, state_d;
  logic [NW-1:0] in_cnt_q, in_cnt_d;
  logic [RW-1:0] orow_q, orow_d;
  logic [CW-1:0] ocol_q, ocol_d;
  logic          mode_q, mode_d;
  logic          busy_q, busy_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_border_q, out_border_d;
  logic          out_last_q, out_last_d;
  logic [DW-1:0] win_q [3][3];
  logic [DW-1:0] win_d [3][3];
  logic [DW-1:0] win_n [3][3];

  logic [DW-1:0] lb1_dout, lb2_dout;
  logic          out_free, in_fire, flush_step, step, emit;
  logic [2:0]    row_ok, col_ok;
  logic [DW-1:0] win_max, win_min, win_diff;

  // Output register can take a new result this cycle.
  assign out_free = out_ready || !out_valid_q;

  always_comb begin
    case (state_q)
      FILL:    in_ready = 1'b1;
      STREAM:  in_ready = out_free;
      default: in_ready = 1'b0;
    endcase
  end

  assign in_fire = in_valid && in_ready;
  // Once the last result is loaded, flushing stops until it is consumed.
  assign flush_step = (state_q == FLUSH) && out_free && !(out_valid_q && out_last_q);
  assign step = in_fire || flush_step;
  assign emit = (in_fire && (state_q == STREAM)) || flush_step;

  // lb1 yields the pixel one row above the incoming one, lb2 two rows above.
  // Both keep shifting during FLUSH so the last rows still see their neighbours.
  line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .clk (clk), .en (step), .din (in_data), .dout (lb1_dout)
  );
  line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb2 (
    .clk (clk), .en (step), .din (lb1_dout), .dout (lb2_dout)
  );

  // Window after this step: column 2 is newest, row 0 is oldest row.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_n[i][0] = win_q[i][1];
      win_n[i][1] = win_q[i][2];
    end
    win_n[0][2] = lb2_dout;
    win_n[1][2] = lb1_dout;
    win_n[2][2] = in_data;
    win_d = step ? win_n : win_q;
  end

  // Out-of-image neighbours are masked by the centre's coordinates, which also
  // hides row wrap, flush garbage and stale line-buffer contents.
  assign row_ok = {orow_q != ROW_LAST, 1'b1, orow_q != '0};
  assign col_ok = {ocol_q != COL_LAST, 1'b1, ocol_q != '0};

  always_comb begin
    win_max = win_n[1][1];
    win_min = win_n[1][1];
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (row_ok[i] && col_ok[j] && ((mode_q == MODE_8N) || (i == 1) || (j == 1))) begin
          if (win_n[i][j] > win_max) win_max = win_n[i][j];
          if (win_n[i][j] < win_min) win_min = win_n[i][j];
        end
      end
    end
    win_diff = win_max - win_min;
  end

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    orow_d       = orow_q;
    ocol_d       = ocol_q;
    mode_d       = mode_q;
    busy_d       = busy_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;
    out_border_d = out_border_q;
    out_last_d   = out_last_q;

    if (emit) begin
      out_valid_d  = 1'b1;
      out_border_d = (win_diff >= THRESH);
      out_data_d   = (win_diff >= THRESH) ? '0 : win_n[1][1];
      out_last_d   = (orow_q == ROW_LAST) && (ocol_q == COL_LAST);
      if (ocol_q == COL_LAST) begin
        ocol_d = '0;
        orow_d = orow_q + 1'b1;
      end else begin
        ocol_d = ocol_q + 1'b1;
      end
    end

    case (state_q)
      FILL: begin
        if (in_fire) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == '0) begin
            mode_d = mode_8n;
            busy_d = 1'b1;
          end
          if (in_cnt_q == FILL_LAST) state_d = STREAM;
        end
      end
      STREAM: begin
        if (in_fire) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == IN_LAST) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (out_valid_q && out_last_q && out_ready) begin
          state_d    = FILL;
          in_cnt_d   = '0;
          orow_d     = '0;
          ocol_d     = '0;
          busy_d     = 1'b0;
          out_last_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      in_cnt_q     <= '0;
      orow_q       <= '0;
      ocol_q       <= '0;
      mode_q       <= MODE_4N;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_border_q <= 1'b0;
      out_last_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      orow_q       <= orow_d;
      ocol_q       <= ocol_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_border_q <= out_border_d;
      out_last_q   <= out_last_d;
      win_q        <= win_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_border = out_border_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule
